l2_arbiter: RTL and testbench

- Shares the single L2 line port (256-bit, read/write/resp handshake) between the L1 I-cache miss port (read-only) and the L1 D-cache miss/writeback port.
- Sits between both L1 caches and l2_cache.
- Latches the granted request, holds it stable on the L2 port until mem_resp, then routes rdata and resp back to the owner.
- Round-robin or fixed D-priority arbitration, chosen by parameter.

---
 rtl/l2_arbiter_pkg.sv | 20 ++
 rtl/l2_arbiter_if.sv | 39 +++
 rtl/l2_arbiter_picker.sv | 29 ++
 rtl/l2_arbiter.sv | 117 +++++++++++
 tb/tb_l2_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 port arbiter: FSM states, requester ids and latched op.
package l2_arb_types;

  typedef enum logic [1:0] {
    L2ARB_IDLE,
    L2ARB_SERVE_I,
    L2ARB_SERVE_D
  } l2arb_state_t;

  typedef enum logic {
    L2ARB_REQ_I,
    L2ARB_REQ_D
  } l2arb_req_t;

  typedef enum logic {
    L2ARB_OP_READ,
    L2ARB_OP_WRITE
  } l2arb_op_t;

endpackage

// File: rtl/l2_arbiter_if.sv
// Bundles the I-cache miss port, D-cache miss/writeback port and the L2 line port.
// master: the surroundings (L1 caches + l2_cache); slave: the arbiter itself.
interface l2_arbiter_if #(
  parameter int unsigned s_line = 256,
  parameter int unsigned s_addr = 32
);

  logic [s_addr-1:0] i_address;
  logic              i_read;
  logic [s_line-1:0] i_rdata256;
  logic              i_resp;

  logic [s_addr-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [s_line-1:0] d_wdata256;
  logic [s_line-1:0] d_rdata256;
  logic              d_resp;

  logic [s_addr-1:0] mem_address;
  logic [s_line-1:0] mem_wdata256;
  logic              mem_read;
  logic              mem_write;
  logic [s_line-1:0] mem_rdata256;
  logic              mem_resp;

  modport master (
    output i_address, i_read, d_address, d_read, d_write, d_wdata256, mem_rdata256, mem_resp,
    input  i_rdata256, i_resp, d_rdata256, d_resp, mem_address, mem_wdata256, mem_read,
           mem_write
  );

  modport slave (
    input  i_address, i_read, d_address, d_read, d_write, d_wdata256, mem_rdata256, mem_resp,
    output i_rdata256, i_resp, d_rdata256, d_resp, mem_address, mem_wdata256, mem_read,
           mem_write
  );

endinterface

// File: rtl/l2_arbiter_picker.sv
// Combinational grant selection between the two effective (mask-filtered) requests.
module l2_arb_picker
  import l2_arb_types::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       i_req,
  input  logic       d_req,
  input  l2arb_req_t last_grant,
  output logic       grant_valid,
  output l2arb_req_t grant
);

  // Single requester wins outright; contention resolved by policy.
  always_comb begin
    grant_valid = i_req | d_req;
    grant       = L2ARB_REQ_I;
    if (i_req && d_req) begin
      if (ROUND_ROBIN) begin
        grant = (last_grant == L2ARB_REQ_I) ? L2ARB_REQ_D : L2ARB_REQ_I;
      end else begin
        grant = L2ARB_REQ_D;
      end
    end else if (d_req) begin
      grant = L2ARB_REQ_D;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 line port between the I-cache and D-cache miss ports.
// The granted request is latched and held on the L2 port until mem_resp.
module l2_arbiter
  import l2_arb_types::*;
#(
  parameter int unsigned s_line      = 256,
  parameter int unsigned s_addr      = 32,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  l2_arbiter_if.slave bus
);

  l2arb_state_t      state_q, state_d;
  l2arb_req_t        last_grant_q, last_grant_d;
  l2arb_op_t         op_q, op_d;
  logic              mask_i_q, mask_i_d;
  logic              mask_d_q, mask_d_d;
  logic [s_addr-1:0] addr_q, addr_d;
  logic [s_line-1:0] wdata_q, wdata_d;

  logic       i_req, d_req, grant_valid;
  l2arb_req_t grant;

  // The mask keeps a just-served requester out of the first IDLE cycle after its resp.
  assign i_req = bus.i_read & ~mask_i_q;
  assign d_req = (bus.d_read | bus.d_write) & ~mask_d_q;

  l2_arb_picker #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_picker (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  // L2 port is driven from latched state only, so requester changes never leak through.
  assign bus.mem_address  = addr_q;
  assign bus.mem_wdata256 = wdata_q;
  assign bus.mem_read     = (state_q == L2ARB_SERVE_I) ||
                            ((state_q == L2ARB_SERVE_D) && (op_q == L2ARB_OP_READ));
  assign bus.mem_write    = (state_q == L2ARB_SERVE_D) && (op_q == L2ARB_OP_WRITE);
  assign bus.i_rdata256   = bus.mem_rdata256;
  assign bus.d_rdata256   = bus.mem_rdata256;

  // Next-state, latch capture and completion pulses.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    mask_i_d     = 1'b0;
    mask_d_d     = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    bus.i_resp   = 1'b0;
    bus.d_resp   = 1'b0;
    unique case (state_q)
      L2ARB_IDLE: begin
        if (grant_valid) begin
          if (grant == L2ARB_REQ_D) begin
            state_d = L2ARB_SERVE_D;
            addr_d  = bus.d_address;
            wdata_d = bus.d_wdata256;
            // Read and write together is treated as a write.
            op_d    = bus.d_write ? L2ARB_OP_WRITE : L2ARB_OP_READ;
          end else begin
            state_d = L2ARB_SERVE_I;
            addr_d  = bus.i_address;
            op_d    = L2ARB_OP_READ;
          end
        end
      end
      L2ARB_SERVE_I: begin
        if (bus.mem_resp) begin
          bus.i_resp   = 1'b1;
          state_d      = L2ARB_IDLE;
          last_grant_d = L2ARB_REQ_I;
          mask_i_d     = 1'b1;
        end
      end
      L2ARB_SERVE_D: begin
        if (bus.mem_resp) begin
          bus.d_resp   = 1'b1;
          state_d      = L2ARB_IDLE;
          last_grant_d = L2ARB_REQ_D;
          mask_d_d     = 1'b1;
        end
      end
      default: state_d = L2ARB_IDLE;
    endcase
  end

  // State and latch registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= L2ARB_IDLE;
      last_grant_q <= L2ARB_REQ_I;
      op_q         <= L2ARB_OP_READ;
      mask_i_q     <= 1'b0;
      mask_d_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      mask_i_q     <= mask_i_d;
      mask_d_q     <= mask_d_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed scenarios plus random traffic on a round-robin instance,
// checked every cycle against a transaction-level model; a fixed-priority instance gets
// a directed contention check.
module tb_l2_arbiter;

  localparam int unsigned SL = 256;
  localparam int unsigned SA = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l2_arbiter_if #(.s_line(SL), .s_addr(SA)) bus1 ();
  l2_arbiter_if #(.s_line(SL), .s_addr(SA)) bus0 ();

  l2_arbiter #(.s_line(SL), .s_addr(SA), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  l2_arbiter #(.s_line(SL), .s_addr(SA), .ROUND_ROBIN(1'b0)) dut_fix (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the L2 port (0 none, 1 I, 2 D) and the owned transaction.
  int           srv      = 0;
  int           last_win = 1;
  int           blk      = 0;
  int           lat_left = 0;
  int           next_lat = 0;
  bit           was_rst  = 1'b0;
  bit           prev_ei  = 1'b0;
  bit           prev_ed  = 1'b0;
  logic [31:0]  t_addr   = '0;
  logic [255:0] t_wdata  = '0;
  bit           t_write  = 1'b0;
  logic [255:0] l2_data  = '0;
  bit           idle_resp_en = 1'b0;

  bit           obs_i = 1'b0;
  bit           obs_d = 1'b0;
  logic [255:0] obs_rdata = '0;
  int           obs_log[$];

  int           fix_sc = 0;
  int           fix_log[$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of the round-robin instance: L2 responder, checks, model update.
  task automatic cycle();
    bit ei, ed, want_i, want_d;
    int pick;
    bus1.mem_resp     = 1'b0;
    bus1.mem_rdata256 = rst ? l2_data : '0;
    if (rst) begin
      if (srv != 0) bus1.mem_resp = (lat_left == 0);
      else          bus1.mem_resp = idle_resp_en && ($urandom_range(7) == 0);
    end
    #1;
    ei = (srv == 1) && bus1.mem_resp;
    ed = (srv == 2) && bus1.mem_resp;
    check_eq("mem_read", bus1.mem_read, (srv == 1) || (srv == 2 && !t_write));
    check_eq("mem_write", bus1.mem_write, (srv == 2) && t_write);
    check_eq("i_resp", bus1.i_resp, ei);
    check_eq("d_resp", bus1.d_resp, ed);
    check_eq("resp_excl", bus1.i_resp & bus1.d_resp, 1'b0);
    check_eq("i_rdata", bus1.i_rdata256, bus1.mem_rdata256);
    check_eq("d_rdata", bus1.d_rdata256, bus1.mem_rdata256);
    if (srv != 0) check_eq("mem_address", bus1.mem_address, t_addr);
    if (srv == 2 && t_write) check_eq("mem_wdata", bus1.mem_wdata256, t_wdata);
    if (was_rst) begin
      check_eq("rst_address", bus1.mem_address, 32'h0);
      check_eq("rst_wdata", bus1.mem_wdata256, 256'h0);
    end
    obs_i     = bus1.i_resp;
    obs_d     = bus1.d_resp;
    obs_rdata = bus1.i_resp ? bus1.i_rdata256 : bus1.d_rdata256;
    if (obs_i) obs_log.push_back(1);
    if (obs_d) obs_log.push_back(2);

    was_rst = !rst;
    if (!rst) begin
      srv      = 0;
      last_win = 1;
      blk      = 0;
    end else if (srv == 0) begin
      want_i = bus1.i_read && (blk != 1);
      want_d = (bus1.d_read || bus1.d_write) && (blk != 2);
      blk    = 0;
      pick   = 0;
      if (want_i && want_d) pick = (last_win == 1) ? 2 : 1;
      else if (want_i)      pick = 1;
      else if (want_d)      pick = 2;
      if (pick == 1) begin
        srv     = 1;
        t_addr  = bus1.i_address;
        t_write = 1'b0;
      end else if (pick == 2) begin
        srv     = 2;
        t_addr  = bus1.d_address;
        t_wdata = bus1.d_wdata256;
        t_write = bus1.d_write;
      end
      lat_left = next_lat;
    end else if (bus1.mem_resp) begin
      last_win = srv;
      blk      = srv;
      srv      = 0;
    end else begin
      lat_left--;
    end
    prev_ei = ei;
    prev_ed = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_resp(input int who, input int maxc, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < maxc && !seen; k++) begin
      cycle();
      seen = (who == 1) ? obs_i : obs_d;
    end
    check_eq(tag, seen, 1'b1);
  endtask

  task automatic rand_drive();
    int r;
    rst      = ($urandom_range(299) != 0);
    next_lat = $urandom_range(3);
    l2_data  = {8{$urandom}};
    if (bus1.i_read) begin
      if (prev_ei) begin
        if ($urandom_range(1) == 0) bus1.i_read = 1'b0;
        else                        bus1.i_address = $urandom;
      end else if ($urandom_range(31) == 0) begin
        bus1.i_read = 1'b0;
      end else if ($urandom_range(7) == 0) begin
        bus1.i_address = $urandom;
      end
    end else if ($urandom_range(2) == 0) begin
      bus1.i_read    = 1'b1;
      bus1.i_address = $urandom;
    end
    if (bus1.d_read || bus1.d_write) begin
      if (prev_ed) begin
        if ($urandom_range(1) == 0) begin
          bus1.d_read  = 1'b0;
          bus1.d_write = 1'b0;
        end else begin
          bus1.d_address  = $urandom;
          bus1.d_wdata256 = {8{$urandom}};
        end
      end else if ($urandom_range(31) == 0) begin
        bus1.d_read  = 1'b0;
        bus1.d_write = 1'b0;
      end else if ($urandom_range(7) == 0) begin
        bus1.d_address  = $urandom;
        bus1.d_wdata256 = {8{$urandom}};
      end
    end else if ($urandom_range(2) == 0) begin
      r               = $urandom_range(15);
      bus1.d_write    = (r < 8);
      bus1.d_read     = (r >= 7);
      bus1.d_address  = $urandom;
      bus1.d_wdata256 = {8{$urandom}};
    end
  endtask

  // One clock of the fixed-priority instance; L2 answers in the second serve cycle.
  task automatic fix_cycle();
    bus0.mem_resp     = (fix_sc >= 1) && (bus0.mem_read || bus0.mem_write);
    bus0.mem_rdata256 = {8{$urandom}};
    #1;
    check_eq("fix_resp_excl", bus0.i_resp & bus0.d_resp, 1'b0);
    if (bus0.d_resp) fix_log.push_back(2);
    if (bus0.i_resp) fix_log.push_back(1);
    fix_sc = ((bus0.mem_read || bus0.mem_write) && !bus0.mem_resp) ? fix_sc + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic fix_until(input int n, input string tag);
    for (int k = 0; k < 30 && fix_log.size() < n; k++) fix_cycle();
    check_eq(tag, fix_log.size() >= n, 1'b1);
  endtask

  initial begin
    bus1.i_address = 32'h0000_1040; bus1.i_read = 1'b1;
    bus1.d_address = '0; bus1.d_read = 1'b0; bus1.d_write = 1'b0; bus1.d_wdata256 = '0;
    bus1.mem_rdata256 = '0; bus1.mem_resp = 1'b0;
    bus0.i_address = '0; bus0.i_read = 1'b0;
    bus0.d_address = '0; bus0.d_read = 1'b0; bus0.d_write = 1'b0; bus0.d_wdata256 = '0;
    bus0.mem_rdata256 = '0; bus0.mem_resp = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles with i_read high, then a single I read with 3-cycle L2 latency.
    cycle();
    cycle();
    rst      = 1'b1;
    next_lat = 3;
    l2_data  = {32{8'hA5}};
    obs_log.delete();
    run_until_resp(1, 12, "i_read_done");
    check_eq("i_rdata_a5", obs_rdata, {32{8'hA5}});
    bus1.i_read = 1'b0;
    cycle();
    check_eq("i_resp_count", obs_log.size(), 1);

    // D writeback.
    obs_log.delete();
    bus1.d_write    = 1'b1;
    bus1.d_address  = 32'h8000_0020;
    bus1.d_wdata256 = {8{32'hDEAD_BEEF}};
    next_lat        = 2;
    run_until_resp(2, 12, "d_write_done");
    bus1.d_write = 1'b0;
    cycle();
    check_eq("d_resp_count", obs_log.size(), 1);

    // Contention from reset: D first (last grant resets to I), then I, then D.
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    obs_log.delete();
    bus1.i_read = 1'b1; bus1.i_address = 32'h0000_0100;
    bus1.d_read = 1'b1; bus1.d_address = 32'h0000_0200;
    next_lat = 1;
    for (int k = 0; k < 40 && obs_log.size() < 3; k++) cycle();
    check_eq("rr_grants", obs_log.size() >= 3, 1'b1);
    if (obs_log.size() >= 3) begin
      check_eq("rr_order0", obs_log[0], 2);
      check_eq("rr_order1", obs_log[1], 1);
      check_eq("rr_order2", obs_log[2], 2);
    end
    bus1.i_read = 1'b0; bus1.d_read = 1'b0;
    cycle();
    cycle();

    // Address stability mid-transaction, then D still high after its resp loses to I.
    obs_log.delete();
    bus1.d_read = 1'b1; bus1.d_address = 32'h0000_4000;
    next_lat = 3;
    cycle();
    cycle();
    bus1.d_address = 32'h0000_5000;
    run_until_resp(2, 10, "stab_d_done");
    bus1.i_read = 1'b1; bus1.i_address = 32'h0000_6000;
    next_lat = 0;
    cycle();
    bus1.d_read = 1'b0;
    run_until_resp(1, 10, "mask_i_done");
    bus1.i_read = 1'b0;
    cycle();
    check_eq("mask_count", obs_log.size(), 2);
    if (obs_log.size() == 2) check_eq("mask_second", obs_log[1], 1);

    // Random traffic, including stray mem_resp in IDLE and occasional mid-run resets.
    idle_resp_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      rand_drive();
      cycle();
    end
    idle_resp_en = 1'b0;
    rst = 1'b1;
    bus1.i_read = 1'b0; bus1.d_read = 1'b0; bus1.d_write = 1'b0;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();

    // Fixed priority: after a D-only transaction, simultaneous requests still go to D;
    // the D requester held past its resp is masked, so I follows.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    fix_log.delete();
    bus0.d_read = 1'b1; bus0.d_address = 32'h0000_7000;
    fix_until(1, "fix_first");
    bus0.d_read = 1'b0;
    fix_cycle();
    fix_cycle();
    bus0.i_read = 1'b1; bus0.i_address = 32'h0000_8000;
    bus0.d_read = 1'b1; bus0.d_address = 32'h0000_9000;
    fix_until(2, "fix_second");
    fix_until(3, "fix_third");
    bus0.i_read = 1'b0; bus0.d_read = 1'b0;
    fix_cycle();
    check_eq("fix_count", fix_log.size(), 3);
    if (fix_log.size() == 3) begin
      check_eq("fix_order0", fix_log[0], 2);
      check_eq("fix_order1", fix_log[1], 2);
      check_eq("fix_order2", fix_log[2], 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
